// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: rPLL dynamic divider reconfiguration and lock supervisor.
// All logic runs on the PLL reference clock. The rPLL instance lives outside
// this block; this block drives its RESET, FBDSEL and IDSEL inputs and
// qualifies its LOCK output.
//
//  state        | meaning
//  -------------+-------------------------------------------------------------
//  ST_RST       | PLL held in reset for RESET_CYCLES cycles, dividers applied
//  ST_WAIT_LOCK | reset released, waiting for lock_s with timeout
//  ST_STABLE    | lock_s seen, counting LOCK_STABLE consecutive lock cycles
//  ST_LOCKED    | qualified lock, requests accepted, lock loss triggers relock
//  ST_FAIL      | retries exhausted, PLL held in reset until a valid request
module pll_dyn_ctrl #(
   parameter int                        NUM_PROFILES    = 4,
   parameter logic [6*NUM_PROFILES-1:0] PROFILE_FBDIV   = {6'd3, 6'd2, 6'd1, 6'd0},
   parameter logic [6*NUM_PROFILES-1:0] PROFILE_IDIV    = {6'd1, 6'd1, 6'd1, 6'd0},
   parameter int                        DEFAULT_PROFILE = 1,
   parameter int                        RESET_CYCLES    = 16,
   parameter int                        LOCK_STABLE     = 64,
   parameter int                        LOCK_TIMEOUT    = 4096,
   parameter int                        MAX_RETRY       = 3
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [3:0] req_profile,
   output logic       req_ready,
   output logic       bad_req,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [5:0] pll_fdiv,
   output logic [5:0] pll_idiv,
   output logic       locked,
   output logic       busy,
   output logic       error,
   output logic [3:0] active_profile
);

   localparam int RCW = $clog2(RESET_CYCLES + 1);
   localparam int TOW = $clog2(LOCK_TIMEOUT + 1);
   localparam int SCW = $clog2(LOCK_STABLE + 1);
   localparam int RTW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [RCW-1:0] RC_LOAD  = RCW'(RESET_CYCLES - 1);
   localparam logic [TOW-1:0] TO_LOAD  = TOW'(LOCK_TIMEOUT - 1);
   localparam logic [SCW-1:0] SC_LOAD  = SCW'(LOCK_STABLE - 1);
   localparam logic [RTW-1:0] RT_MAX   = RTW'(MAX_RETRY);
   localparam logic [3:0]     DEF_PROF = 4'(DEFAULT_PROFILE);

   typedef enum logic [2:0] {
      ST_RST,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_LOCKED,
      ST_FAIL
   } state_t;

   state_t         r_state;
   logic           r_lock_meta;
   logic           r_lock_s;
   logic [RCW-1:0] r_rst_cnt;
   logic [TOW-1:0] r_timer;
   logic [SCW-1:0] r_stable_cnt;
   logic [RTW-1:0] r_retry;
   logic           w_req_in_range;

   // The rPLL dynamic select inputs are inverted: it expects 63 - SEL.
   function automatic logic [5:0] f_fdiv(input logic [3:0] idx);
      return 6'd63 - PROFILE_FBDIV[6*idx +: 6];
   endfunction

   function automatic logic [5:0] f_idiv(input logic [3:0] idx);
      return 6'd63 - PROFILE_IDIV[6*idx +: 6];
   endfunction

   // Range check of the requested profile index.
   always_comb begin
      w_req_in_range = ({1'b0, req_profile} < 5'(NUM_PROFILES));
   end

   // Lock synchroniser, sequencing FSM, timers and registered outputs.
   always_ff @(posedge clkin) begin
      if (reset) begin
         r_state        <= ST_RST;
         r_lock_meta    <= 1'b0;
         r_lock_s       <= 1'b0;
         r_rst_cnt      <= RC_LOAD;
         r_timer        <= TO_LOAD;
         r_stable_cnt   <= SC_LOAD;
         r_retry        <= '0;
         pll_reset      <= 1'b1;
         pll_fdiv       <= f_fdiv(DEF_PROF);
         pll_idiv       <= f_idiv(DEF_PROF);
         active_profile <= DEF_PROF;
         locked         <= 1'b0;
         busy           <= 1'b1;
         error          <= 1'b0;
         req_ready      <= 1'b0;
         bad_req        <= 1'b0;
      end else begin
         r_lock_meta <= pll_lock;
         r_lock_s    <= r_lock_meta;
         bad_req     <= 1'b0;
         case (r_state)
            ST_RST: begin
               if (r_rst_cnt == '0) begin
                  r_state      <= ST_WAIT_LOCK;
                  pll_reset    <= 1'b0;
                  r_timer      <= TO_LOAD;
                  r_stable_cnt <= SC_LOAD;
               end else begin
                  r_rst_cnt <= r_rst_cnt - RCW'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (r_lock_s) begin
                  r_state      <= ST_STABLE;
                  r_stable_cnt <= SC_LOAD;
               end else if (r_timer == '0) begin
                  if (r_retry < RT_MAX) begin
                     r_retry   <= r_retry + RTW'(1);
                     r_state   <= ST_RST;
                     r_rst_cnt <= RC_LOAD;
                     pll_reset <= 1'b1;
                  end else begin
                     r_state   <= ST_FAIL;
                     pll_reset <= 1'b1;
                     error     <= 1'b1;
                     busy      <= 1'b0;
                     req_ready <= 1'b1;
                  end
               end else begin
                  r_timer <= r_timer - TOW'(1);
               end
            end
            ST_STABLE: begin
               // Timeout keeps running across lock glitches so a chattering
               // lock cannot postpone the timeout indefinitely.
               if (r_timer != '0) begin
                  r_timer <= r_timer - TOW'(1);
               end
               if (!r_lock_s) begin
                  r_state      <= ST_WAIT_LOCK;
                  r_stable_cnt <= SC_LOAD;
               end else if (r_stable_cnt == '0) begin
                  r_state   <= ST_LOCKED;
                  locked    <= 1'b1;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  r_retry   <= '0;
               end else begin
                  r_stable_cnt <= r_stable_cnt - SCW'(1);
               end
            end
            ST_LOCKED: begin
               // A valid request takes priority over a same-cycle lock loss.
               if (req_valid && w_req_in_range) begin
                  r_state        <= ST_RST;
                  r_rst_cnt      <= RC_LOAD;
                  r_retry        <= '0;
                  pll_reset      <= 1'b1;
                  pll_fdiv       <= f_fdiv(req_profile);
                  pll_idiv       <= f_idiv(req_profile);
                  active_profile <= req_profile;
                  locked         <= 1'b0;
                  busy           <= 1'b1;
                  req_ready      <= 1'b0;
               end else begin
                  if (req_valid) begin
                     bad_req <= 1'b1;
                  end
                  if (!r_lock_s) begin
                     r_state   <= ST_RST;
                     r_rst_cnt <= RC_LOAD;
                     r_retry   <= '0;
                     pll_reset <= 1'b1;
                     locked    <= 1'b0;
                     busy      <= 1'b1;
                     req_ready <= 1'b0;
                  end
               end
            end
            ST_FAIL: begin
               if (req_valid && w_req_in_range) begin
                  r_state        <= ST_RST;
                  r_rst_cnt      <= RC_LOAD;
                  r_retry        <= '0;
                  pll_reset      <= 1'b1;
                  pll_fdiv       <= f_fdiv(req_profile);
                  pll_idiv       <= f_idiv(req_profile);
                  active_profile <= req_profile;
                  error          <= 1'b0;
                  busy           <= 1'b1;
                  req_ready      <= 1'b0;
               end else if (req_valid) begin
                  bad_req <= 1'b1;
               end
            end
            default: begin
               r_state   <= ST_RST;
               r_rst_cnt <= RC_LOAD;
               pll_reset <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// tb_pll_dyn_ctrl: directed bench for pll_dyn_ctrl with default parameters.
module tb_pll_dyn_ctrl;

   logic       clkin = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic [3:0] req_profile = 4'd0;
   logic       req_ready;
   logic       bad_req;
   logic       pll_lock = 1'b0;
   logic       pll_reset;
   logic [5:0] pll_fdiv;
   logic [5:0] pll_idiv;
   logic       locked;
   logic       busy;
   logic       error;
   logic [3:0] active_profile;

   int n_tests = 0;
   int n_fail  = 0;

   pll_dyn_ctrl u_dut (
      .clkin          (clkin),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_profile    (req_profile),
      .req_ready      (req_ready),
      .bad_req        (bad_req),
      .pll_lock       (pll_lock),
      .pll_reset      (pll_reset),
      .pll_fdiv       (pll_fdiv),
      .pll_idiv       (pll_idiv),
      .locked         (locked),
      .busy           (busy),
      .error          (error),
      .active_profile (active_profile)
   );

   always #5 clkin = ~clkin;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clkin);
      #1;
   endtask

   // Edges until pll_reset drops, starting just after the RST entry edge.
   task automatic measure_reset(output int n);
      n = 0;
      while (pll_reset && n < 200) begin
         tick(1);
         n++;
      end
   endtask

   // Edges until locked rises.
   task automatic wait_locked(output int n);
      n = 0;
      while (!locked && n < 5000) begin
         tick(1);
         n++;
      end
   endtask

   task automatic request(input logic [3:0] idx);
      req_valid   = 1'b1;
      req_profile = idx;
      tick(1);
      req_valid   = 1'b0;
   endtask

   initial begin
      int n;
      int rises;
      int hi;
      logic prev;

      // Reset values.
      tick(3);
      check("rst_pll_reset", 32'(pll_reset), 1);
      check("rst_fdiv", 32'(pll_fdiv), 62);
      check("rst_idiv", 32'(pll_idiv), 62);
      check("rst_active", 32'(active_profile), 1);
      check("rst_locked", 32'(locked), 0);
      check("rst_busy", 32'(busy), 1);
      check("rst_error", 32'(error), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_bad_req", 32'(bad_req), 0);

      // Initial lock with default profile.
      reset = 1'b0;
      measure_reset(n);
      check("init_rst_width", 32'(n), 16);
      tick(10);
      check("init_fdiv_wait", 32'(pll_fdiv), 62);
      pll_lock = 1'b1;
      wait_locked(n);
      check("init_lock_latency", 32'(n), 67);
      check("init_busy", 32'(busy), 0);
      check("init_ready", 32'(req_ready), 1);
      check("init_fdiv", 32'(pll_fdiv), 62);
      check("init_idiv", 32'(pll_idiv), 62);

      // Out-of-range request in LOCKED.
      request(4'd7);
      check("bad_pulse", 32'(bad_req), 1);
      check("bad_locked", 32'(locked), 1);
      check("bad_fdiv", 32'(pll_fdiv), 62);
      check("bad_active", 32'(active_profile), 1);
      tick(1);
      check("bad_pulse_end", 32'(bad_req), 0);
      check("bad_locked2", 32'(locked), 1);

      // Switch to profile 3.
      request(4'd3);
      pll_lock = 1'b0;
      check("p3_ready", 32'(req_ready), 0);
      check("p3_locked", 32'(locked), 0);
      check("p3_pll_reset", 32'(pll_reset), 1);
      check("p3_fdiv", 32'(pll_fdiv), 60);
      check("p3_idiv", 32'(pll_idiv), 62);
      check("p3_active", 32'(active_profile), 3);
      measure_reset(n);
      check("p3_rst_width", 32'(n), 16);
      tick(5);
      pll_lock = 1'b1;
      wait_locked(n);
      check("p3_lock_latency", 32'(n), 67);
      check("p3_fdiv_locked", 32'(pll_fdiv), 60);

      // One-cycle lock glitch in LOCKED -> lock-loss relock, same profile.
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      tick(1);
      check("loss_locked_hold", 32'(locked), 1);
      tick(1);
      check("loss_locked", 32'(locked), 0);
      check("loss_pll_reset", 32'(pll_reset), 1);
      check("loss_fdiv", 32'(pll_fdiv), 60);
      check("loss_active", 32'(active_profile), 3);
      measure_reset(n);
      check("loss_rst_width", 32'(n), 16);
      wait_locked(n);
      check("loss_relock", 32'(n), 65);

      // Glitch during STABLE restarts the stable count.
      request(4'd1);
      pll_lock = 1'b0;
      measure_reset(n);
      check("st_rst_width", 32'(n), 16);
      pll_lock = 1'b1;
      tick(19);
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      wait_locked(n);
      check("st_glitch_latency", 32'(n), 67);
      check("st_fdiv", 32'(pll_fdiv), 62);

      // Lock loss and request in the same cycle: request wins.
      pll_lock = 1'b0;
      tick(2);
      request(4'd2);
      check("sim_fdiv", 32'(pll_fdiv), 61);
      check("sim_idiv", 32'(pll_idiv), 62);
      check("sim_active", 32'(active_profile), 2);
      check("sim_pll_reset", 32'(pll_reset), 1);
      measure_reset(n);
      check("sim_rst_width", 32'(n), 16);
      tick(3);
      pll_lock = 1'b1;
      wait_locked(n);
      check("sim_lock_latency", 32'(n), 67);
      check("sim_active_locked", 32'(active_profile), 2);

      // No lock at all: retries then FAIL.
      request(4'd1);
      pll_lock = 1'b0;
      n = 0;
      rises = 0;
      hi = 1;
      prev = pll_reset;
      while (!error && n < 20000) begin
         tick(1);
         n++;
         if (pll_reset && !prev) rises++;
         if (pll_reset && !error) hi++;
         prev = pll_reset;
      end
      check("fail_time", 32'(n), 16448);
      check("fail_rises", 32'(rises), 4);
      check("fail_rst_cycles", 32'(hi), 64);
      check("fail_error", 32'(error), 1);
      check("fail_pll_reset", 32'(pll_reset), 1);
      check("fail_ready", 32'(req_ready), 1);
      check("fail_busy", 32'(busy), 0);
      tick(20);
      check("fail_hold", 32'(error), 1);
      request(4'd0);
      check("fail_clr_error", 32'(error), 0);
      check("fail_clr_fdiv", 32'(pll_fdiv), 63);
      check("fail_clr_idiv", 32'(pll_idiv), 63);
      check("fail_clr_active", 32'(active_profile), 0);
      check("fail_clr_busy", 32'(busy), 1);

      // Reset mid-sequence restores defaults.
      tick(4);
      reset = 1'b1;
      tick(2);
      check("mid_rst_fdiv", 32'(pll_fdiv), 62);
      check("mid_rst_active", 32'(active_profile), 1);
      check("mid_rst_pll_reset", 32'(pll_reset), 1);
      check("mid_rst_ready", 32'(req_ready), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
